// File: rtl/pong_pkg.sv
// Shared geometry, coordinate type and ball state encoding for the pong engine
// and the screen-draw wrapper.
package pong_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [11:0] wide_t;

  typedef enum logic [1:0] {IDLE, PLAY, POINT, GAME_OVER} ball_state_t;

  localparam int LEFT     = 160;
  localparam int RIGHT    = 1120;
  localparam int TOP      = 128;
  localparam int BOTTOM   = 896;
  localparam int P1X      = 225;
  localparam int P2X      = 1030;
  localparam int PADDLE_W = 25;
  localparam int PADDLE_H = 125;

  localparam coord_t CENTRE_X = 11'd640;
  localparam coord_t CENTRE_Y = 11'd512;

  function automatic wide_t widen(input coord_t c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/pong_ball_engine_tick_gen.sv
// Free-running divider: tick is registered and high for the one cycle where
// the counter sits at DIV-1.
module game_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [CW-1:0] cnt_t;

  cnt_t cnt_q, cnt_d;
  logic tick_q;

  always_comb begin
    cnt_d = (cnt_q == cnt_t'(DIV - 1)) ? '0 : cnt_q + cnt_t'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == cnt_t'(DIV - 1));
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pong_ball_engine.sv
// Ball motion, wall/paddle bounce, miss scoring and serve/game-over sequencing.
// state     | meaning
// IDLE      | ball parked at centre, waiting for serve
// PLAY      | ball moving, collisions evaluated each tick
// POINT     | ball parked after a miss, counting SERVE_WAIT ticks
// GAME_OVER | a player reached SCORE_MAX; serve clears scores
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int TICK_DIV   = 2097152,
  parameter int STEP       = 4,
  parameter int BALL_R     = 15,
  parameter int SERVE_WAIT = 64,
  parameter int SCORE_MAX  = 9
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        serve_n,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  p1_score,
  output logic [3:0]  p2_score,
  output logic        game_over,
  output logic        tick
);

  localparam int HOLD_W = $clog2(SERVE_WAIT + 1);
  typedef logic [HOLD_W-1:0] hold_t;
  typedef logic [3:0]        score_t;

  // Limits pre-arranged so every compare is a plain 12-bit test on the
  // pre-move coordinate, with no subtraction that could underflow.
  localparam wide_t  BOT_LIM   = wide_t'(BOTTOM - BALL_R - STEP);
  localparam wide_t  TOP_LIM   = wide_t'(TOP + BALL_R + STEP);
  localparam coord_t BOT_CLAMP = coord_t'(BOTTOM - BALL_R);
  localparam coord_t TOP_CLAMP = coord_t'(TOP + BALL_R);
  localparam wide_t  P2_LO     = wide_t'(P2X - BALL_R - STEP);
  localparam wide_t  P2_HI     = wide_t'(P2X - BALL_R);
  localparam wide_t  P1_LO     = wide_t'(P1X + PADDLE_W + BALL_R);
  localparam wide_t  P1_HI     = wide_t'(P1X + PADDLE_W + BALL_R + STEP);
  localparam wide_t  RIGHT_LIM = wide_t'(RIGHT - BALL_R - STEP);
  localparam wide_t  LEFT_LIM  = wide_t'(LEFT + BALL_R + STEP);

  ball_state_t state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  score_t      p1_q, p1_d, p2_q, p2_d;
  hold_t       hold_q, hold_d;
  logic        serve_s1_q, serve_s2_q, serve_s3_q;
  logic        serve_pulse;
  logic        tick_w;
  wide_t       xe, ye;
  logic        in_p1, in_p2;
  score_t      p1_inc, p2_inc;

  game_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .tick_o (tick_w)
  );

  function automatic score_t sat_inc(input score_t s);
    return (s >= score_t'(SCORE_MAX)) ? s : s + score_t'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      serve_s1_q <= 1'b1;
      serve_s2_q <= 1'b1;
      serve_s3_q <= 1'b1;
    end else begin
      serve_s1_q <= serve_n;
      serve_s2_q <= serve_s1_q;
      serve_s3_q <= serve_s2_q;
    end
  end

  assign serve_pulse = serve_s3_q & ~serve_s2_q;

  assign xe     = widen(x_q);
  assign ye     = widen(y_q);
  assign in_p1  = (ye >= widen(p1_y)) && (ye <= widen(p1_y) + wide_t'(PADDLE_H));
  assign in_p2  = (ye >= widen(p2_y)) && (ye <= widen(p2_y) + wide_t'(PADDLE_H));
  assign p1_inc = sat_inc(p1_q);
  assign p2_inc = sat_inc(p2_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        x_d = CENTRE_X;
        y_d = CENTRE_Y;
        if (serve_pulse) state_d = PLAY;
      end
      PLAY: begin
        if (tick_w) begin
          if (dy_q) begin
            if (ye >= BOT_LIM) begin
              y_d  = BOT_CLAMP;
              dy_d = 1'b0;
            end else begin
              y_d = y_q + coord_t'(STEP);
            end
          end else begin
            if (ye <= TOP_LIM) begin
              y_d  = TOP_CLAMP;
              dy_d = 1'b1;
            end else begin
              y_d = y_q - coord_t'(STEP);
            end
          end
          // A miss parks the ball, so the vertical move above is discarded.
          if (dx_q) begin
            if (xe >= P2_LO && xe <= P2_HI && in_p2) begin
              x_d  = coord_t'(P2_HI);
              dx_d = 1'b0;
            end else if (xe >= RIGHT_LIM) begin
              p1_d    = p1_inc;
              x_d     = CENTRE_X;
              y_d     = CENTRE_Y;
              hold_d  = '0;
              state_d = (p1_inc == score_t'(SCORE_MAX)) ? GAME_OVER : POINT;
            end else begin
              x_d = x_q + coord_t'(STEP);
            end
          end else begin
            if (xe >= P1_LO && xe <= P1_HI && in_p1) begin
              x_d  = coord_t'(P1_LO);
              dx_d = 1'b1;
            end else if (xe <= LEFT_LIM) begin
              p2_d    = p2_inc;
              x_d     = CENTRE_X;
              y_d     = CENTRE_Y;
              hold_d  = '0;
              state_d = (p2_inc == score_t'(SCORE_MAX)) ? GAME_OVER : POINT;
            end else begin
              x_d = x_q - coord_t'(STEP);
            end
          end
        end
      end
      POINT: begin
        x_d = CENTRE_X;
        y_d = CENTRE_Y;
        // dx still points at the side that conceded, which is where the
        // next rally starts.
        if (tick_w) begin
          if (hold_q == hold_t'(SERVE_WAIT - 1)) begin
            state_d = PLAY;
            dy_d    = 1'b1;
          end else begin
            hold_d = hold_q + hold_t'(1);
          end
        end
      end
      GAME_OVER: begin
        x_d = CENTRE_X;
        y_d = CENTRE_Y;
        if (serve_pulse) begin
          p1_d    = '0;
          p2_d    = '0;
          dx_d    = 1'b1;
          dy_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= CENTRE_X;
      y_q     <= CENTRE_Y;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      p1_q    <= '0;
      p2_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      hold_q  <= hold_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign p1_score  = p1_q;
  assign p2_score  = p2_q;
  assign game_over = (state_q == GAME_OVER);
  assign tick      = tick_w;

endmodule
